// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants
// and the parity helper that both the TX and RX paths use.
package uart_rx_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  // Oversampling: 16 ticks per bit, mid-bit sample at the 8th tick
  localparam int OS_RATE = 16;
  localparam int OS_MID  = 7;

  // Parity bit for a data word (zero-extended to 8 bits).
  // odd=0 gives even parity: the bit makes the total count of ones even.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: divider/parity configuration and serial line in,
// received byte, strobes and status out. The master is whoever drives the
// line and consumes bytes; the slave is the receiver itself.
interface uart_rx_if #(
  parameter int DIV_WIDTH = 10,
  parameter int DATA_BITS = 8
);

  logic [DIV_WIDTH-1:0] final_value;
  logic                 parity_en;
  logic                 parity_odd;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_error;
  logic                 framing_error;
  logic                 busy;

  modport master (
    output final_value, parity_en, parity_odd, rx_in,
    input  rx_data, rx_valid, parity_error, framing_error, busy
  );

  modport slave (
    input  final_value, parity_en, parity_odd, rx_in,
    output rx_data, rx_valid, parity_error, framing_error, busy
  );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: a mod-(final_value+1) counter that runs only
// while enabled and sits at zero otherwise, so every frame starts with the
// same tick phase relative to start detection.
module uart_rx_tick_gen #(
  parameter int DIV_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] final_value,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = en && (count == final_value);

  // Divider counter: cleared when disabled, wraps to zero on each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver. Synchronizes the serial line, oversamples it at 16x the
// baud rate and recovers start, data (LSB first), optional parity and stop
// bits. Each completed frame produces a one-cycle rx_valid or framing_error
// strobe. Configuration is captured at start detection so that changes
// mid-frame only take effect on the next frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV_WIDTH = 10,
  parameter int DATA_BITS = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int          BCW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]  OS_SAMP  = 4'(OS_MID);
  localparam logic [3:0]  OS_LAST  = 4'(OS_RATE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  // Synchronized line
  logic rx_meta;
  logic rxs;

  // FSM
  uart_state_e state_q;
  uart_state_e state_d;

  // Per-frame configuration snapshot
  logic [DIV_WIDTH-1:0] fv_q;
  logic                 par_en_q;
  logic                 par_odd_q;

  // Oversampling and bit tracking
  logic                 tick;
  logic                 tick_en;
  logic [3:0]           os_q;
  logic [BCW-1:0]       bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;

  // Registered outputs
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 parity_error_q;
  logic                 framing_error_q;

  // FSM control strobes
  logic start_det;
  logic os_clr;
  logic shift_en;
  logic par_sample;
  logic stop_good;
  logic stop_bad;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx_in;
      rxs     <= rx_meta;
    end
  end

  assign tick_en = (state_q != IDLE);

  uart_rx_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (tick_en),
    .final_value (fv_q),
    .tick        (tick)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_d    = state_q;
    start_det  = 1'b0;
    os_clr     = 1'b0;
    shift_en   = 1'b0;
    par_sample = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          start_det = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (tick && (os_q == OS_SAMP)) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            os_clr  = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tick && (os_q == OS_LAST)) begin
          shift_en = 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick && (os_q == OS_LAST)) begin
          par_sample = 1'b1;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (tick && (os_q == OS_LAST)) begin
          if (rxs) begin
            stop_good = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration snapshot taken at start detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q      <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else if (start_det) begin
      fv_q      <= bus.final_value;
      par_en_q  <= bus.parity_en;
      par_odd_q <= bus.parity_odd;
    end
  end

  // Oversample counter: held at zero in IDLE, realigned after the start sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_q <= '0;
    end else if ((state_q == IDLE) || os_clr) begin
      os_q <= '0;
    end else if (tick) begin
      os_q <= os_q + 4'd1;
    end
  end

  // Data capture: right shift so the first (LSB) bit ends up in bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q   <= '0;
      shift_q <= '0;
    end else if (start_det) begin
      bit_q   <= '0;
    end else if (shift_en) begin
      bit_q   <= bit_q + BCW'(1);
      shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
    end
  end

  // Parity mismatch flag, cleared for every new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (start_det) begin
      par_err_q <= 1'b0;
    end else if (par_sample) begin
      par_err_q <= (rxs != uart_parity(8'(shift_q), par_odd_q));
    end
  end

  // Frame-end outputs: data load and one-cycle strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_valid_q      <= stop_good;
      parity_error_q  <= stop_good && par_err_q;
      framing_error_q <= stop_bad;
      if (stop_good || stop_bad) begin
        rx_data_q <= shift_q;
      end
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the TX path. Oversamples the serial line at 16× the baud rate using a divider tick derived from `final_value`. Recovers start/data/optional parity/stop bits and presents each received byte with a one-cycle valid strobe plus error flags. Sits between the pad-side `rx_in` line and the byte-level consumer logic.

## Interface
- `DIV_WIDTH`, 10 — width of the divider compare value.
- `DATA_BITS`, 8 — data bits per frame, 5..8. Sent LSB first.

- `clk`  in  1  — clock.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `final_value`  in  DIV_WIDTH  — divider terminal count; tick period = `final_value`+1 clk cycles; bit period = 16 ticks.
- `parity_en`  in  1  — 1: a parity bit follows the data bits.
- `parity_odd`  in  1  — 1: odd parity; 0: even parity.
- `rx_in`  in  1  — asynchronous serial line; idle high.
- `rx_data`  out  DATA_BITS  — last received data word.
- `rx_valid`  out  1  — one-cycle pulse when the frame completes with a valid stop bit.
- `parity_error`  out  1  — one-cycle pulse, coincident with `rx_valid`, when parity mismatches.
- `framing_error`  out  1  — one-cycle pulse when the stop bit samples low.
- `busy`  out  1  — high whenever the FSM is not in IDLE.

## Operation
- Input synchronizer: two flops on `rx_in`, reset to 1. The FSM sees only the synchronized value `rxs`.
- `final_value`, `parity_en` and `parity_odd` are latched on start detection and held for the frame. Changes mid-frame have no effect until the next frame.
- Tick counter:
  - Cleared and held at 0 in IDLE.
  - Otherwise counts 0..latched `final_value`; `tick` = (count == final_value), and the counter wraps to 0 on `tick`.
- 4-bit oversample counter `os` advances on each `tick`.
- Bit counter counts 0..DATA_BITS-1.
- FSM states:
  - IDLE: `rxs`==0 → START; clear counters, latch configuration.
  - START: on the 8th tick (`os`==7), sample at mid-bit.
    - `rxs`==1 → IDLE (false start; no flags).
    - `rxs`==0 → DATA; clear `os`.
  - DATA: on each 16th tick (`os`==15), shift `rxs` into the MSB of the shift register (right shift).
    - After DATA_BITS samples → PARITY if `parity_en`, else STOP.
  - PARITY: on the 16th tick, sample the parity bit.
    - Expected bit = XOR(data) ^ `parity_odd`; record a mismatch.
    - Then → STOP.
  - STOP: on the 16th tick, sample at mid stop bit.
    - `rxs`==1: load `rx_data`, pulse `rx_valid` (plus `parity_error` if a mismatch was recorded) → IDLE.
    - `rxs`==0: load `rx_data`, pulse `framing_error` → WAIT_HIGH. `parity_error` is suppressed.
  - WAIT_HIGH: stays until `rxs`==1, then → IDLE. This prevents a line break from being taken as a new start.
- With DATA_BITS<8, `rx_data` is right-aligned; the register is exactly DATA_BITS wide.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `parity_error`=0, `framing_error`=0, `busy`=0.
  - FSM in IDLE; synchronizer flops at 1.
- Start detection: 2 clk after the `rx_in` falling edge (synchronizer), plus 1 clk to enter START.
- Sample points: start mid-bit at 8 ticks after detection; each subsequent bit 16 ticks later.
- `rx_valid`, `parity_error` and `framing_error` register on the clk after the stop-sample tick and are high exactly one cycle.
- The FSM re-enters IDLE half a stop bit early, so back-to-back frames with no idle gap are received.
- `final_value`=0 is legal: tick every cycle, bit period 16 clk.
- `rst_n` asserted mid-frame: immediate return to reset values. The partial frame is discarded and produces no pulses.
- `rx_data` holds its value between frames; it changes only at frame end.

## Structure
- Shared UART package holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - the `OS_RATE`=16 and `OS_MID`=7 constants;
  - a parity function shared with TX.
- One sub-module: `uart_rx_tick_gen`. It is the enable-gated mod-(`final_value`+1) counter that outputs `tick`, and is cleared when its enable is low.

## Test plan
All scenarios use `final_value`=3, giving tick = 4 clk and bit = 64 clk.
- 8N1 frame 0xA5 → one `rx_valid` pulse, `rx_data`=0xA5, no error pulses, `busy` low after.
- `rx_in` low glitch of 20 clk in idle → no pulses; `busy` rises, then returns to 0 about 32 clk after detection.
- Frame 0x3C with stop bit 0, line then held low 300 clk → one `framing_error` pulse, no `rx_valid`, `busy` high until the line rises; a following 0x5A frame is received correctly.
- `parity_en`=1, `parity_odd`=0, data 0x07 with parity bit 0 → `rx_valid` and `parity_error` in the same cycle, `rx_data`=0x07; the same frame with parity bit 1 gives no `parity_error`.
- Back-to-back 0x00 then 0xFF with no idle gap → two `rx_valid` pulses 640 clk apart with correct data.
- `rst_n` pulsed during data bit 4 of frame 0x81 → no pulses, outputs at reset values; a following 0x81 frame is received correctly.
